// File: rtl/sfx_sequencer_if.sv
// Port bundle for the sound-effect sequencer. The game logic drives the
// trigger, timing and mute inputs; the sequencer drives the tone-generator controls.
interface sfx_sequencer_if #(
    parameter int NUM_EVENTS = 2,
    parameter int TONE_W     = 4
);
    localparam int EV_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    logic                  tick;
    logic [NUM_EVENTS-1:0] trig;
    logic                  mute;
    logic                  play;
    logic [TONE_W-1:0]     tone;
    logic                  busy;
    logic [EV_W-1:0]       cur_event;
    logic                  done;

    modport master (
        output tick, trig, mute,
        input  play, tone, busy, cur_event, done
    );

    modport slave (
        input  tick, trig, mute,
        output play, tone, busy, cur_event, done
    );
endinterface

// File: rtl/sfx_sequencer.sv
// Prioritised multi-channel sound-effect sequencer. Each trigger channel plays
// its own note sequence from TONE_TABLE, paced by the shared tick strobe.
module sfx_sequencer #(
    parameter int NUM_EVENTS = 2,
    parameter int NOTES      = 2,
    parameter int TONE_W     = 4,
    parameter int NOTE_TICKS = 1,
    parameter int GAP_TICKS  = 0,
    parameter logic [NUM_EVENTS*NOTES*TONE_W-1:0] TONE_TABLE =
        {(NUM_EVENTS*NOTES){TONE_W'(3)}}
) (
    input logic            clk,
    input logic            reset,
    sfx_sequencer_if.slave bus
);
    localparam int EV_W   = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int TCK_W  = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t                state;
    logic [NUM_EVENTS-1:0] trig_q;
    logic [NUM_EVENTS-1:0] pending;
    logic [EV_W-1:0]       cur_event;
    logic [NOTE_W-1:0]     note;
    logic [TCK_W-1:0]      tick_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  play_q;
    logic [TONE_W-1:0]     tone;
    logic                  busy;
    logic                  done;

    logic [NUM_EVENTS-1:0] trig_edge;
    logic [NUM_EVENTS-1:0] req;
    logic [NUM_EVENTS-1:0] win_mask;
    logic [EV_W-1:0]       winner;
    logic                  req_any;
    logic                  preempt;
    logic                  note_end;
    logic                  seq_end;
    logic                  gap_end;
    logic                  start;

    function automatic logic [TONE_W-1:0] tone_at(input logic [EV_W-1:0] ev,
                                                  input logic [NOTE_W-1:0] nt);
        return TONE_TABLE[(int'(ev) * NOTES + int'(nt)) * TONE_W +: TONE_W];
    endfunction

    // Stored requests plus fresh rising edges compete; the lowest index wins.
    always_comb begin
        trig_edge = bus.trig & ~trig_q;
        req       = pending | trig_edge;
        req_any   = |req;
        win_mask  = req & (~req + NUM_EVENTS'(1));
        winner    = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = EV_W'(i);
            end
        end
        preempt  = (state != IDLE) && req_any && (winner < cur_event);
        note_end = (state == PLAY) && bus.tick && (tick_cnt == TCK_W'(NOTE_TICKS - 1));
        seq_end  = note_end && (note == NOTE_W'(NOTES - 1));
        gap_end  = (state == GAP) && bus.tick && (gap_cnt == GAP_W'(GAP_TICKS - 1));
        start    = ((state == IDLE) && req_any) || preempt || (seq_end && req_any);
    end

    // A start (fresh, chained after a finished sequence, or preempting) always wins
    // over the normal note/gap progression; the displaced event is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            trig_q    <= '0;
            pending   <= '0;
            cur_event <= '0;
            note      <= '0;
            tick_cnt  <= '0;
            gap_cnt   <= '0;
            play_q    <= 1'b0;
            tone      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            trig_q <= bus.trig;
            done   <= seq_end && !preempt;
            if (start) begin
                state     <= PLAY;
                cur_event <= winner;
                note      <= '0;
                tick_cnt  <= '0;
                gap_cnt   <= '0;
                play_q    <= 1'b1;
                busy      <= 1'b1;
                tone      <= tone_at(winner, '0);
                pending   <= req & ~win_mask;
            end else begin
                pending <= req;
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                    end
                    PLAY: begin
                        if (seq_end) begin
                            state    <= IDLE;
                            play_q   <= 1'b0;
                            busy     <= 1'b0;
                            tone     <= '0;
                            note     <= '0;
                            tick_cnt <= '0;
                        end else if (note_end) begin
                            note     <= note + NOTE_W'(1);
                            tick_cnt <= '0;
                            if (GAP_TICKS > 0) begin
                                state  <= GAP;
                                play_q <= 1'b0;
                                tone   <= '0;
                            end else begin
                                tone <= tone_at(cur_event, note + NOTE_W'(1));
                            end
                        end else if (bus.tick) begin
                            tick_cnt <= tick_cnt + TCK_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state   <= PLAY;
                            gap_cnt <= '0;
                            play_q  <= 1'b1;
                            tone    <= tone_at(cur_event, note);
                        end else if (bus.tick) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Mute only silences the generator; sequencing carries on underneath it.
    assign bus.play      = play_q & ~bus.mute;
    assign bus.tone      = tone;
    assign bus.busy      = busy;
    assign bus.cur_event = cur_event;
    assign bus.done      = done;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: a default-parameter instance (legacy hit
// sound) and a three-channel, three-note instance with gaps.
module tb_sfx_sequencer;

    logic        clk;
    logic        reset;
    logic        tick;
    int          cyc;
    int          checks;
    int          errors;

    // Record layout: {dut, kind, event, tone, ticks[7:0], playMode, 4'h0}
    // kind 0 = tone segment, 1 = done pulse, 2 = busy dropped without done
    logic [31:0] expQ[$];

    logic        segOpen[2];
    logic [7:0]  segKey[2];
    int          segTicks[2];
    int          segCyc[2];
    int          segPlay[2];
    logic        prevBusy[2];

    sfx_sequencer_if #(.NUM_EVENTS(2), .TONE_W(4)) busA ();
    sfx_sequencer_if #(.NUM_EVENTS(3), .TONE_W(4)) busB ();

    sfx_sequencer dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    sfx_sequencer #(
        .NUM_EVENTS (3),
        .NOTES      (3),
        .TONE_W     (4),
        .NOTE_TICKS (2),
        .GAP_TICKS  (1),
        .TONE_TABLE (36'h987654321)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    // 100 MHz-style clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick strobe every fourth cycle, updated just after each rising edge
    initial begin
        cyc       = 0;
        tick      = 1'b0;
        busA.tick = 1'b0;
        busB.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc       = cyc + 1;
            tick      = (cyc % 4 == 0);
            busA.tick = tick;
            busB.tick = tick;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mkRec(input int d, input int kind, input logic [3:0] ev,
                                          input logic [3:0] tn, input int ticks, input int pm);
        return {4'(d), 4'(kind), ev, tn, 8'(ticks), 4'(pm), 4'h0};
    endfunction

    task automatic emitObs(input logic [31:0] obs);
        logic [31:0] exp;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_output", obs, 32'hFFFF_FFFF);
        end else begin
            exp = expQ.pop_front();
            checkOutput("scoreboard", obs, exp);
        end
    endtask

    // Compresses the output stream into segments of constant (event, tone) while busy
    task automatic monitorStep(input int d, input logic busy, input logic done,
                               input logic play, input logic tk,
                               input logic [3:0] ev, input logic [3:0] tn);
        logic [7:0] key;
        int         pm;
        key = {ev, tn};
        if (segOpen[d] && (!busy || key != segKey[d])) begin
            pm = (segPlay[d] == 0) ? 0 : ((segPlay[d] == segCyc[d]) ? 1 : 2);
            emitObs(mkRec(d, 0, segKey[d][7:4], segKey[d][3:0], segTicks[d], pm));
            segOpen[d] = 1'b0;
        end
        if (done) begin
            emitObs(mkRec(d, 1, 4'h0, 4'h0, 0, int'(busy)));
        end
        if (prevBusy[d] && !busy && !done) begin
            emitObs(mkRec(d, 2, ev, tn, 0, 0));
        end
        prevBusy[d] = busy;
        if (busy && !segOpen[d]) begin
            segOpen[d]  = 1'b1;
            segKey[d]   = key;
            segTicks[d] = 0;
            segCyc[d]   = 0;
            segPlay[d]  = 0;
        end
        if (segOpen[d]) begin
            segTicks[d] = segTicks[d] + int'(tk);
            segCyc[d]   = segCyc[d] + 1;
            segPlay[d]  = segPlay[d] + int'(play);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                segOpen[d]  = 1'b0;
                prevBusy[d] = 1'b0;
            end
        end else begin
            monitorStep(0, busA.busy, busA.done, busA.play, busA.tick,
                        {3'b000, busA.cur_event}, busA.tone);
            monitorStep(1, busB.busy, busB.done, busB.play, busB.tick,
                        {2'b00, busB.cur_event}, busB.tone);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int d, input logic [2:0] bits);
        if (d == 0) busA.trig = bits[1:0];
        else        busB.trig = bits;
        step();
        busA.trig = '0;
        busB.trig = '0;
    endtask

    // Expected record stream for one complete, unpreempted sequence
    task automatic pushFull(input int d, input int ev, input int mutedNote, input int doneBusy);
        if (d == 0) begin
            expQ.push_back(mkRec(0, 0, 4'(ev), 4'h3, 2, 1));
        end else begin
            for (int n = 0; n < 3; n++) begin
                expQ.push_back(mkRec(1, 0, 4'(ev), 4'(ev * 3 + n + 1), 2, (n == mutedNote) ? 0 : 1));
                if (n < 2) expQ.push_back(mkRec(1, 0, 4'(ev), 4'h0, 1, 0));
            end
        end
        expQ.push_back(mkRec(d, 1, 4'h0, 4'h0, 0, doneBusy));
    endtask

    task automatic waitTone(input logic [3:0] val);
        for (int i = 0; i < 100; i++) begin
            if (busB.tone == val) break;
            step();
        end
        checkOutput("wait_tone", 32'(busB.tone), 32'(val));
    endtask

    task automatic drainAndCheck(input int d, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0) break;
            step();
        end
        repeat (6) step();
        checkOutput({tag, "_leftover"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "_idle"}, 32'((d == 0) ? busA.busy : busB.busy), 32'd0);
        expQ.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        busA.trig = '0;
        busA.mute = 1'b0;
        busB.trig = '0;
        busB.mute = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstA_play", 32'(busA.play), 32'd0);
        checkOutput("rstA_tone", 32'(busA.tone), 32'd0);
        checkOutput("rstA_busy", 32'(busA.busy), 32'd0);
        checkOutput("rstA_done", 32'(busA.done), 32'd0);
        checkOutput("rstA_event", 32'(busA.cur_event), 32'd0);
        checkOutput("rstB_play", 32'(busB.play), 32'd0);
        checkOutput("rstB_tone", 32'(busB.tone), 32'd0);
        checkOutput("rstB_busy", 32'(busB.busy), 32'd0);
        reset = 1'b0;
        step();

        // Legacy sound: trig[1] pulsed on a tick cycle (that tick must not count)
        for (int i = 0; i < 8; i++) begin
            if (tick) break;
            step();
        end
        pushFull(0, 1, -1, 0);
        applyStimulus(0, 3'b010);
        checkOutput("A_latency_play", 32'(busA.play), 32'd1);
        checkOutput("A_latency_tone", 32'(busA.tone), 32'd3);
        checkOutput("A_latency_event", 32'(busA.cur_event), 32'd1);
        drainAndCheck(0, "A_trig1");

        pushFull(0, 0, -1, 0);
        applyStimulus(0, 3'b001);
        drainAndCheck(0, "A_trig0");

        // Single three-note sequence with gaps
        pushFull(1, 2, -1, 0);
        applyStimulus(1, 3'b100);
        checkOutput("B_first_tone", 32'(busB.tone), 32'd7);
        checkOutput("B_first_event", 32'(busB.cur_event), 32'd2);
        drainAndCheck(1, "B_single");

        // Simultaneous requests: e0 first, then e2 chained with no idle cycle
        pushFull(1, 0, -1, 1);
        pushFull(1, 2, -1, 0);
        applyStimulus(1, 3'b101);
        drainAndCheck(1, "B_chain");

        // Preemption of e2 on tone 8 by e0
        expQ.push_back(mkRec(1, 0, 4'h2, 4'h7, 2, 1));
        expQ.push_back(mkRec(1, 0, 4'h2, 4'h0, 1, 0));
        expQ.push_back(mkRec(1, 0, 4'h2, 4'h8, 0, 1));
        pushFull(1, 0, -1, 0);
        applyStimulus(1, 3'b100);
        waitTone(4'h8);
        applyStimulus(1, 3'b001);
        checkOutput("B_preempt_tone", 32'(busB.tone), 32'd1);
        checkOutput("B_preempt_event", 32'(busB.cur_event), 32'd0);
        drainAndCheck(1, "B_preempt");

        // Double retrigger of e1 collapses to one play; note 2 of e0 muted
        pushFull(1, 0, 1, 1);
        pushFull(1, 1, -1, 0);
        applyStimulus(1, 3'b001);
        applyStimulus(1, 3'b010);
        waitTone(4'h2);
        busB.mute = 1'b1;
        applyStimulus(1, 3'b010);
        waitTone(4'h0);
        busB.mute = 1'b0;
        drainAndCheck(1, "B_mute");

        // Asynchronous reset in the middle of a note with a pending retrigger
        applyStimulus(1, 3'b100);
        step();
        applyStimulus(1, 3'b100);
        checkOutput("rst_mid_busy_before", 32'(busB.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_mid_play", 32'(busB.play), 32'd0);
        checkOutput("rst_mid_busy", 32'(busB.busy), 32'd0);
        checkOutput("rst_mid_tone", 32'(busB.tone), 32'd0);
        checkOutput("rst_mid_done", 32'(busB.done), 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (24) step();
        checkOutput("rst_after_busy", 32'(busB.busy), 32'd0);
        checkOutput("rst_after_event", 32'(busB.cur_event), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Parametrised sound-effect sequencer. It replaces the single fixed-tone, two-step hit sound with NUM_EVENTS prioritised event channels. Each channel plays its own multi-note tone sequence from a parameter table, timed by the shared tick strobe. It sits between the game-object hit detectors and the tone generator/audio driver.

Parameters:
NUM_EVENTS, 2, number of trigger channels; index 0 is the highest priority.
NOTES, 2, notes per event sequence (>=1).
TONE_W, 4, tone code width.
NOTE_TICKS, 1, ticks each note is held (>=1).
GAP_TICKS, 0, silent ticks between notes of one sequence; 0 means notes are back-to-back.
TONE_TABLE, all entries 4'h3, packed NUM_EVENTS*NOTES*TONE_W bits; entry (e*NOTES+n) is at bits [(e*NOTES+n)*TONE_W +: TONE_W].

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
tick  in  1  one-cycle timing strobe (note-duration base).
trig  in  NUM_EVENTS  event request levels; rising edge = one request.
mute  in  1  forces play=0; sequencing continues unaffected.
play  out  1  tone generator enable.
tone  out  TONE_W  current tone code.
busy  out  1  high in PLAY or GAP.
cur_event  out  max(1,$clog2(NUM_EVENTS))  index of the event now sounding.
done  out  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Reset (async, immediate): state=IDLE, pending=0, edge history=0, all counters 0, play=0, tone=0, busy=0, cur_event=0, done=0.
- Edge detect: edge[i]=trig[i]&~trig_q[i]. trig_q resets to 0, so trig high at reset release is one edge.
- req = pending | edge. Winner = lowest set index of req.
- IDLE: if req!=0, next cycle goes to PLAY with event=winner, note=0, tick_cnt=0. Winner's pending bit is cleared; other req bits are stored in pending. Latency: trig edge in cycle n gives play=1 in cycle n+1.
- PLAY: play=~mute, tone=TONE_TABLE[cur_event][note]. Each tick increments tick_cnt.
  - On the tick where tick_cnt==NOTE_TICKS-1, the note ends.
  - If note<NOTES-1: note++ and tick_cnt=0. Go to GAP if GAP_TICKS>0, else stay in PLAY.
  - If last note: done=1 for that one clock. If req!=0, start the winner directly with no idle cycle; else go to IDLE.
  - A tick in the IDLE cycle before the start is not counted.
- GAP: play=0, tone=0, busy=1. Count GAP_TICKS ticks, then return to PLAY for the next note.
- Preemption (PLAY or GAP): if req has a bit with index < cur_event, the next cycle is PLAY with that event at note 0. The preempted event is dropped: no done pulse, no resume, and its pending bit is not set.
- A req at index >= cur_event (including a retrigger of the same event) sets pending. Multiple edges collapse to one pending play.
- Preemption has priority over a note-end in the same cycle; no done pulse is issued in that case.
- tone=0 outside PLAY. cur_event holds its last value in IDLE.
- Default parameters reproduce the legacy hit sound: 2 ticks of tone 3, with either trig bit acting as the trigger.

Test Plan:
Default params, tick every 4 cycles, 1-cycle pulse on trig[1] -> play=1 and tone=3 from the next cycle, through the 2nd counted tick; then play=0, done=1 for exactly one cycle, busy=0.
Params NUM_EVENTS=3, NOTES=3, NOTE_TICKS=2, GAP_TICKS=1, table e0={1,2,3}, e1={4,5,6}, e2={7,8,9}; pulse trig[2] -> tone 7 for 2 ticks, play=0 for 1 tick, 8, gap, 9, done; busy high throughout, cur_event=2.
Same params; trig[0] and trig[2] rise in the same cycle -> e0 plays 1,2,3, done, then e2 starts on the next cycle with no IDLE cycle and plays 7,8,9; cur_event goes 0 then 2.
Same params; trig[0] rises while e2 is on tone 8 -> next cycle tone=1, cur_event=0; e2 never resumes; exactly one done pulse (at the end of e0).
Same params; during e0, trig[1] pulses twice and mute is held for note 2 -> play=0 during note 2 while timing is unchanged; e1 plays 4,5,6 exactly once after e0.
Same params; reset asserted mid-note between clock edges -> play, busy, tone and done go to 0 immediately; after release with trig low, the block stays IDLE and no pending replay occurs.
